// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog heartbeat generator.
//   wdt_state_e  : internal 3-bit FSM state (TRIPPED needs its own code)
//   ENC_*        : 2-bit debug encodings driven on the state port
//   KC_W_DEFAULT : default width of the saturating kick counter
//   state_enc()  : maps an internal state to its debug encoding
package wdt_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_KICK    = 3'd2,
        S_HOLD    = 3'd3,
        S_TRIPPED = 3'd4
    } wdt_state_e;

    localparam logic [1:0] ENC_IDLE    = 2'd0;
    localparam logic [1:0] ENC_COLLECT = 2'd1;
    localparam logic [1:0] ENC_KICK    = 2'd2;
    localparam logic [1:0] ENC_HOLD    = 2'd3;

    localparam int unsigned KC_W_DEFAULT = 16;

    // TRIPPED shares the HOLD code on the debug port.
    function automatic logic [1:0] state_enc(input wdt_state_e s);
        case (s)
            S_IDLE:    return ENC_IDLE;
            S_COLLECT: return ENC_COLLECT;
            S_KICK:    return ENC_KICK;
            default:   return ENC_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/wdt_heartbeat_gen.sv
// Heartbeat (kick) generator for a watchdog timer.
// Collects liveness pulses from N_SRC supervised sources over a window of
// KICK_PERIOD cycles and issues one heartbeat per window only when every
// masked source checked in; otherwise it withholds the kick and reports the
// silent sources.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   enable         : block enable, low forces IDLE and clears counters
//   alive          : per-source liveness pulses
//   src_mask       : 1 = source supervised
//   wdt_warning    : watchdog warning (sets sticky warn_seen)
//   wdt_triggered  : watchdog triggered (locks the FSM in TRIPPED)
//   heartbeat      : registered 1-cycle kick
//   missing        : masked sources silent in the last failed window
//   warn_seen      : sticky warning flag since enable rose
//   kick_count     : saturating heartbeat count since enable rose
//   state          : debug state encoding
module wdt_heartbeat_gen
    import wdt_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned KICK_PERIOD = 1024,
    parameter int unsigned KC_W        = KC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [N_SRC-1:0] alive,
    input  logic [N_SRC-1:0] src_mask,
    input  logic             wdt_warning,
    input  logic             wdt_triggered,
    output logic             heartbeat,
    output logic [N_SRC-1:0] missing,
    output logic             warn_seen,
    output logic [KC_W-1:0]  kick_count,
    output logic [1:0]       state
);

    localparam int unsigned    TW   = (KICK_PERIOD > 2) ? $clog2(KICK_PERIOD) : 1;
    localparam logic [TW-1:0]  LAST = TW'(KICK_PERIOD - 1);

    wdt_state_e       r_state, w_next_state;
    logic [TW-1:0]    r_timer, w_timer_d;
    logic [N_SRC-1:0] r_seen, w_seen_d;
    logic [N_SRC-1:0] r_missing, w_missing_d;
    logic             r_heartbeat, w_heartbeat_d;
    logic             r_warn, w_warn_d;
    logic [KC_W-1:0]  r_kick, w_kick_d;
    logic [1:0]       r_state_enc, w_state_enc_d;

    logic [N_SRC-1:0] w_seen_next;
    logic             w_all_seen;
    logic             w_win_close;

    // Alive in the current cycle counts toward the window being evaluated.
    assign w_seen_next = r_seen | (alive & src_mask);
    assign w_all_seen  = ((w_seen_next & src_mask) == src_mask);
    assign w_win_close = (r_timer == LAST);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_seen      <= '0;
            r_missing   <= '0;
            r_heartbeat <= 1'b0;
            r_warn      <= 1'b0;
            r_kick      <= '0;
            r_state_enc <= ENC_IDLE;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_timer_d;
            r_seen      <= w_seen_d;
            r_missing   <= w_missing_d;
            r_heartbeat <= w_heartbeat_d;
            r_warn      <= w_warn_d;
            r_kick      <= w_kick_d;
            r_state_enc <= w_state_enc_d;
        end
    end

    // Next-state logic: enable low beats trigger, trigger beats normal flow.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = S_IDLE;
        end else if (wdt_triggered && (r_state != S_IDLE)) begin
            w_next_state = S_TRIPPED;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_COLLECT;
                S_COLLECT: if (w_win_close) w_next_state = w_all_seen ? S_KICK : S_HOLD;
                S_KICK:    w_next_state = S_COLLECT;
                S_HOLD:    if (w_all_seen) w_next_state = S_KICK;
                default:   w_next_state = S_TRIPPED;
            endcase
        end
    end

    // Datapath / output next values. Heartbeat, kick_count and missing are
    // updated on entry to KICK so they are visible during the KICK cycle;
    // the new window's seen vector loads at the end of KICK.
    always_comb begin
        w_timer_d     = '0;
        w_seen_d      = '0;
        w_missing_d   = r_missing;
        w_heartbeat_d = (w_next_state == S_KICK);
        w_warn_d      = r_warn | wdt_warning;
        w_kick_d      = r_kick;
        w_state_enc_d = state_enc(w_next_state);

        if (!enable) begin
            w_warn_d = 1'b0;
            w_kick_d = '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    w_seen_d = w_seen_next;
                    if (w_next_state == S_COLLECT) w_timer_d = r_timer + 1'b1;
                    if (w_next_state == S_HOLD)    w_missing_d = src_mask & ~w_seen_next;
                end
                S_KICK:  w_seen_d = alive & src_mask;
                S_HOLD:  w_seen_d = w_seen_next;
                default: w_seen_d = '0;
            endcase

            if (w_next_state == S_KICK) begin
                w_missing_d = '0;
                w_kick_d    = (r_kick == '1) ? r_kick : r_kick + 1'b1;
            end
        end
    end

    assign heartbeat  = r_heartbeat;
    assign missing    = r_missing;
    assign warn_seen  = r_warn;
    assign kick_count = r_kick;
    assign state      = r_state_enc;

endmodule

// File: tb/tb_wdt_heartbeat_gen.sv
// Directed self-checking bench for wdt_heartbeat_gen (KICK_PERIOD=8, N_SRC=4).
module tb_wdt_heartbeat_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [3:0]  alive;
    logic [3:0]  src_mask;
    logic        wdt_warning;
    logic        wdt_triggered;
    logic        heartbeat;
    logic [3:0]  missing;
    logic        warn_seen;
    logic [15:0] kick_count;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    wdt_heartbeat_gen #(
        .N_SRC(4),
        .KICK_PERIOD(8),
        .KC_W(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .alive(alive),
        .src_mask(src_mask),
        .wdt_warning(wdt_warning),
        .wdt_triggered(wdt_triggered),
        .heartbeat(heartbeat),
        .missing(missing),
        .warn_seen(warn_seen),
        .kick_count(kick_count),
        .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until heartbeat is seen; returns tick count or -1 on timeout.
    task automatic wait_hb(input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (heartbeat === 1'b1) begin
                cnt = i;
                return;
            end
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; alive = '0; src_mask = 4'hF;
        wdt_warning = 1'b0; wdt_triggered = 1'b0;
        #3;
        chk("rst hb", heartbeat, 0);
        chk("rst kick", kick_count, 0);
        chk("rst state", state, 0);
        chk("rst missing", missing, 0);
        chk("rst warn", warn_seen, 0);
        tick();
        rstn = 1'b1;
        tick();

        // 1: all sources alive -> heartbeat every 9 cycles
        enable = 1'b1; alive = 4'hF;
        wait_hb(40, n);
        chk("t1 first period", n, 9);
        chk("t1 kick1", kick_count, 1);
        chk("t1 state kick", state, 2);
        wait_hb(40, n);
        chk("t1 period2", n, 9);
        chk("t1 kick2", kick_count, 2);
        tick();
        chk("t1 hb one cycle", heartbeat, 0);
        chk("t1 state collect", state, 1);
        wait_hb(40, n);
        chk("t1 period3", n, 8);
        chk("t1 kick3", kick_count, 3);

        // 2: source 2 silent -> HOLD, then recovery kick
        alive = 4'b1011;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t2 no hb in window", heartbeat, 0);
        end
        chk("t2 state hold", state, 3);
        chk("t2 missing", missing, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2 hold no hb", heartbeat, 0);
        end
        alive = 4'b0100;
        tick();
        chk("t2 recovery hb", heartbeat, 1);
        chk("t2 missing cleared", missing, 0);
        chk("t2 kick4", kick_count, 4);

        // 4: trigger while in HOLD -> TRIPPED, no kicks, re-enable resumes
        alive = 4'b1011;
        for (int i = 0; i < 9; i++) tick();
        chk("t4 state hold", state, 3);
        chk("t4 missing", missing, 4'b0100);
        wdt_triggered = 1'b1;
        tick();
        wdt_triggered = 1'b0;
        alive = 4'hF;
        chk("t4 tripped enc", state, 3);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("t4 tripped no hb", heartbeat, 0);
        end
        chk("t4 kick frozen", kick_count, 4);
        enable = 1'b0;
        tick();
        chk("t4 idle", state, 0);
        chk("t4 kick cleared", kick_count, 0);
        chk("t4 missing holds", missing, 4'b0100);
        enable = 1'b1;
        tick();
        chk("t4 collect", state, 1);
        wait_hb(40, n);
        chk("t4 resume period", n, 8);
        chk("t4 kick restart", kick_count, 1);
        chk("t4 missing cleared", missing, 0);

        // 3: empty mask -> unconditional kicks
        src_mask = 4'h0; alive = 4'h0;
        wait_hb(40, n);
        chk("t3 period1", n, 9);
        chk("t3 missing", missing, 0);
        chk("t3 kick2", kick_count, 2);
        wait_hb(40, n);
        chk("t3 period2", n, 9);
        chk("t3 kick3", kick_count, 3);

        // 6: sticky warning, enable low clears seen
        src_mask = 4'hF; alive = 4'hF; wdt_warning = 1'b1;
        tick();
        wdt_warning = 1'b0; alive = 4'h0;
        chk("t6 warn set", warn_seen, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6 warn sticky", warn_seen, 1);
        end
        enable = 1'b0;
        tick();
        chk("t6 warn cleared", warn_seen, 0);
        chk("t6 idle", state, 0);
        enable = 1'b1; alive = 4'b1110;
        tick();
        chk("t6 collect", state, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6 no hb", heartbeat, 0);
        end
        chk("t6 hold", state, 3);
        chk("t6 seen cleared", missing, 4'b0001);

        // 5: async reset during a KICK cycle
        alive = 4'hF;
        tick();
        chk("t5 kick hb", heartbeat, 1);
        chk("t5 kick cnt", kick_count, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5 rst hb", heartbeat, 0);
        chk("t5 rst kick", kick_count, 0);
        chk("t5 rst state", state, 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("t5 restart collect", state, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
